// File: rtl/register_file_sb_if.sv
// rtl/register_file_sb_if.sv - write, read, issue and flush bundle for register_file_sb
interface register_file_sb_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  parameter int AW    = $clog2(NREGS)
);
  logic                wr0_en;
  logic [AW-1:0]       wr0_addr;
  logic [XLEN-1:0]     wr0_data;
  logic                wr1_en;
  logic [AW-1:0]       wr1_addr;
  logic [XLEN-1:0]     wr1_data;
  logic [NRD*AW-1:0]   rs_addr;
  logic [NRD*XLEN-1:0] rs_data;
  logic [NRD-1:0]      rs_busy;
  logic                issue_en;
  logic [AW-1:0]       issue_rd;
  logic                issue_ready;
  logic                flush;

  modport master (
    output wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data,
    output rs_addr, issue_en, issue_rd, flush,
    input  rs_data, rs_busy, issue_ready
  );

  modport slave (
    input  wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data,
    input  rs_addr, issue_en, issue_rd, flush,
    output rs_data, rs_busy, issue_ready
  );
endinterface

// File: rtl/register_file_sb.sv
// rtl/register_file_sb.sv - NRD-read/2-write register file with pending-write scoreboard
module register_file_sb #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  parameter int PCW   = 2
) (
  input logic               clk,
  input logic               rst,
  register_file_sb_if.slave bus
);
  localparam int AW = $clog2(NREGS);
  localparam logic [PCW-1:0] CNT_MAX = '1;

  logic [XLEN-1:0] r_mem [NREGS];
  logic [PCW-1:0]  r_cnt [NREGS];

  logic [1:0]      w_dec     [NREGS];
  logic [NREGS-1:0] w_inc;
  logic [PCW+1:0]  w_sum     [NREGS];
  logic [PCW-1:0]  w_cnt_nxt [NREGS];
  logic [AW-1:0]   w_ra      [NRD];
  logic            w_ready;

  // Issue acceptance looks only at the registered count; same-cycle writes do not free a slot.
  assign w_ready = (bus.issue_rd == '0) || (r_cnt[bus.issue_rd] != CNT_MAX);
  assign bus.issue_ready = w_ready;

  // Per-register increment/decrement from this cycle's issue and write ports.
  always_comb begin
    w_inc = '0;
    for (int r = 0; r < NREGS; r++) begin
      w_dec[r] = {1'b0, (bus.wr0_en && (bus.wr0_addr == AW'(r)))} +
                 {1'b0, (bus.wr1_en && (bus.wr1_addr == AW'(r)))};
      w_inc[r] = bus.issue_en && w_ready && (bus.issue_rd == AW'(r));
    end
  end

  // Next pending count: flush clears, otherwise cnt+inc-dec clamped at zero; r0 stays zero.
  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      w_sum[r] = {2'b00, r_cnt[r]} + {{(PCW+1){1'b0}}, w_inc[r]};
      if (r == 0 || bus.flush) begin
        w_cnt_nxt[r] = '0;
      end else if (w_sum[r] > {{PCW{1'b0}}, w_dec[r]}) begin
        w_cnt_nxt[r] = PCW'(w_sum[r] - {{PCW{1'b0}}, w_dec[r]});
      end else begin
        w_cnt_nxt[r] = '0;
      end
    end
  end

  // Read ports: r0 hardwired, wr1 forwarded over wr0 over array; busy nets out arriving writes.
  always_comb begin
    bus.rs_data = '0;
    bus.rs_busy = '0;
    for (int k = 0; k < NRD; k++) begin
      w_ra[k] = bus.rs_addr[k*AW +: AW];
      if (w_ra[k] == '0) begin
        bus.rs_data[k*XLEN +: XLEN] = '0;
      end else if (bus.wr1_en && (bus.wr1_addr == w_ra[k])) begin
        bus.rs_data[k*XLEN +: XLEN] = bus.wr1_data;
      end else if (bus.wr0_en && (bus.wr0_addr == w_ra[k])) begin
        bus.rs_data[k*XLEN +: XLEN] = bus.wr0_data;
      end else begin
        bus.rs_data[k*XLEN +: XLEN] = r_mem[w_ra[k]];
      end
      bus.rs_busy[k] = (w_ra[k] != '0) &&
                       ({2'b00, r_cnt[w_ra[k]]} > {{PCW{1'b0}}, w_dec[w_ra[k]]});
    end
  end

  // Data array: wr1 is applied after wr0 so it wins on a same-register collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) r_mem[r] <= '0;
    end else begin
      if (bus.wr0_en && (bus.wr0_addr != '0)) r_mem[bus.wr0_addr] <= bus.wr0_data;
      if (bus.wr1_en && (bus.wr1_addr != '0)) r_mem[bus.wr1_addr] <= bus.wr1_data;
    end
  end

  // Pending-write counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) r_cnt[r] <= '0;
    end else begin
      for (int r = 0; r < NREGS; r++) r_cnt[r] <= w_cnt_nxt[r];
    end
  end
endmodule

// File: tb/tb_register_file_sb.sv
// tb/tb_register_file_sb.sv - scoreboard bench for register_file_sb
module tb_register_file_sb;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int PCW   = 2;
  localparam int AW    = $clog2(NREGS);

  typedef struct {
    string       tag;
    int          kind;   // 0 data, 1 busy, 2 issue_ready
    int          port;
    logic [31:0] exp;
  } sb_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  sb_t  sb_q [$];

  register_file_sb_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .AW(AW)) bus ();

  register_file_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .PCW(PCW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle();
    bus.wr0_en = 0; bus.wr0_addr = '0; bus.wr0_data = '0;
    bus.wr1_en = 0; bus.wr1_addr = '0; bus.wr1_data = '0;
    bus.issue_en = 0; bus.issue_rd = '0; bus.flush = 0;
    bus.rs_addr = '0;
  endtask

  task automatic wr0(input int a, input logic [31:0] d);
    bus.wr0_en = 1; bus.wr0_addr = AW'(a); bus.wr0_data = d;
  endtask

  task automatic wr1(input int a, input logic [31:0] d);
    bus.wr1_en = 1; bus.wr1_addr = AW'(a); bus.wr1_data = d;
  endtask

  task automatic iss(input int a);
    bus.issue_en = 1; bus.issue_rd = AW'(a);
  endtask

  task automatic rd(input int k, input int a);
    bus.rs_addr[k*AW +: AW] = AW'(a);
  endtask

  task automatic exp_rd(input int k, input logic [31:0] d, input logic b, input string tag);
    sb_t e;
    e.tag = {tag, "_data"}; e.kind = 0; e.port = k; e.exp = d;
    sb_q.push_back(e);
    e.tag = {tag, "_busy"}; e.kind = 1; e.port = k; e.exp = {31'b0, b};
    sb_q.push_back(e);
  endtask

  task automatic exp_rdy(input logic v, input string tag);
    sb_t e;
    e.tag = {tag, "_ready"}; e.kind = 2; e.port = 0; e.exp = {31'b0, v};
    sb_q.push_back(e);
  endtask

  // Let the combinational outputs settle, then pop every pending expectation.
  task automatic drain();
    sb_t e;
    logic [31:0] got;
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      case (e.kind)
        0:       got = bus.rs_data[e.port*XLEN +: XLEN];
        1:       got = {31'b0, bus.rs_busy[e.port]};
        default: got = {31'b0, bus.issue_ready};
      endcase
      check_eq(e.tag, got, e.exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;

    // Reset state on every register and port.
    for (int r = 0; r < NREGS; r++) begin
      rd(0, r); rd(1, NREGS - 1 - r); bus.issue_rd = AW'(r);
      exp_rd(0, 32'h0, 1'b0, "t1_p0");
      exp_rd(1, 32'h0, 1'b0, "t1_p1");
      exp_rdy(1'b1, "t1");
      drain();
    end

    // Write forwarding, array read-back, r0 discard.
    idle(); wr0(5, 32'hDEADBEEF); rd(0, 5); rd(1, 0);
    exp_rd(0, 32'hDEADBEEF, 1'b0, "t2_fwd");
    exp_rd(1, 32'h0, 1'b0, "t2_r0");
    drain(); cyc();
    idle(); rd(0, 5);
    exp_rd(0, 32'hDEADBEEF, 1'b0, "t2_arr");
    drain();
    wr0(0, 32'h1234); rd(1, 0);
    exp_rd(1, 32'h0, 1'b0, "t2_wr_r0");
    drain(); cyc();
    idle(); rd(1, 0);
    exp_rd(1, 32'h0, 1'b0, "t2_r0_after");
    drain();

    // Dual write to one register: wr1 wins.
    idle(); wr0(7, 32'h11); wr1(7, 32'h22); rd(0, 7);
    exp_rd(0, 32'h22, 1'b0, "t3_fwd");
    drain(); cyc();
    idle(); rd(1, 7);
    exp_rd(1, 32'h22, 1'b0, "t3_arr");
    drain();

    // Saturating issue on r3, then drain by writes.
    for (int i = 0; i < 3; i++) begin
      idle(); iss(3); exp_rdy(1'b1, "t4_iss"); drain(); cyc();
    end
    idle(); rd(0, 3); bus.issue_rd = AW'(3);
    exp_rd(0, 32'h0, 1'b1, "t4_full");
    exp_rdy(1'b0, "t4_full");
    drain();
    iss(3); cyc();
    idle(); wr1(3, 32'h33); rd(0, 3); bus.issue_rd = AW'(3);
    exp_rd(0, 32'h33, 1'b1, "t4_w1");
    exp_rdy(1'b0, "t4_w1_samecyc");
    drain(); cyc();
    idle(); rd(0, 3); bus.issue_rd = AW'(3);
    exp_rd(0, 32'h33, 1'b1, "t4_cnt2");
    exp_rdy(1'b1, "t4_cnt2");
    drain();
    wr0(3, 32'h44); exp_rd(0, 32'h44, 1'b1, "t4_w2"); drain(); cyc();
    idle(); wr1(3, 32'h55); rd(0, 3);
    exp_rd(0, 32'h55, 1'b0, "t4_w3");
    drain(); cyc();
    idle(); rd(0, 3);
    exp_rd(0, 32'h55, 1'b0, "t4_empty");
    drain();

    // Issue and write to the same register in one cycle net out.
    iss(3); cyc();
    idle(); iss(3); wr0(3, 32'h66); rd(1, 3);
    exp_rd(1, 32'h66, 1'b0, "t4_net_samecyc");
    drain(); cyc();
    idle(); rd(1, 3);
    exp_rd(1, 32'h66, 1'b1, "t4_net_after");
    drain();
    wr0(3, 32'h67); cyc();
    idle(); rd(1, 3);
    exp_rd(1, 32'h67, 1'b0, "t4_net_done");
    drain();

    // Flush with a concurrent write, then no underflow.
    iss(9); cyc(); iss(9); cyc();
    idle(); rd(0, 9);
    exp_rd(0, 32'h0, 1'b1, "t5_pend");
    drain();
    iss(9); wr0(9, 32'h55); bus.flush = 1;
    exp_rd(0, 32'h55, 1'b1, "t5_flush_samecyc");
    drain(); cyc();
    idle(); rd(0, 9); bus.issue_rd = AW'(9);
    exp_rd(0, 32'h55, 1'b0, "t5_flushed");
    exp_rdy(1'b1, "t5_flushed");
    drain();
    wr0(9, 32'h56); cyc();
    idle(); rd(0, 9); bus.issue_rd = AW'(9);
    exp_rd(0, 32'h56, 1'b0, "t5_noundf");
    exp_rdy(1'b1, "t5_noundf");
    drain();
    iss(9); cyc();
    idle(); rd(0, 9);
    exp_rd(0, 32'h56, 1'b1, "t5_one");
    drain();
    wr1(9, 32'h57); cyc();

    // Asynchronous reset mid-cycle.
    idle(); iss(4); cyc();
    idle(); iss(4); wr0(4, 32'hAA); cyc();
    idle(); rd(0, 4); rd(1, 9); bus.issue_rd = AW'(4);
    exp_rd(0, 32'hAA, 1'b1, "t6_pre");
    exp_rd(1, 32'h57, 1'b0, "t6_pre_r9");
    drain();
    #1 rst = 1;
    exp_rd(0, 32'h0, 1'b0, "t6_rst");
    exp_rd(1, 32'h0, 1'b0, "t6_rst_r9");
    exp_rdy(1'b1, "t6_rst");
    drain();
    @(negedge clk);
    rst = 0;
    exp_rd(0, 32'h0, 1'b0, "t6_post");
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
